// File: rtl/xif_mem_responder.sv
// rtl/xif_mem_responder.sv - XIF memory-channel responder bridging coprocessor requests onto the OBI data port
module xif_mem_responder #(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [X_ID_WIDTH-1:0] mem_req_id_i,
    input  logic [31:0]           mem_req_addr_i,
    input  logic                  mem_req_we_i,
    input  logic [3:0]            mem_req_be_i,
    input  logic [31:0]           mem_req_wdata_i,
    output logic                  mem_resp_exc_o,
    output logic [5:0]            mem_resp_exccode_o,

    output logic                  mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0] mem_result_id_o,
    output logic [31:0]           mem_result_rdata_o,
    output logic                  mem_result_err_o,

    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [31:0]           data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
    localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;

    logic [X_ID_WIDTH-1:0] fifo_id_q [DEPTH];
    logic                  fifo_we_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic misaligned;
    logic full;
    logic push;
    logic pop;

    assign misaligned = mem_req_addr_i[1:0] != 2'b00;
    // A response retiring this cycle frees its slot for a request granted in the same cycle.
    assign full       = (count_q == CNT_W'(DEPTH)) && !data_rvalid_i;

    assign data_req_o   = mem_valid_i && !misaligned && !full;
    assign data_addr_o  = data_req_o ? {mem_req_addr_i[31:2], 2'b00} : 32'h0;
    assign data_we_o    = data_req_o && mem_req_we_i;
    assign data_be_o    = data_req_o ? mem_req_be_i : 4'h0;
    assign data_wdata_o = data_req_o ? mem_req_wdata_i : 32'h0;

    assign push = data_req_o && data_gnt_i;
    assign pop  = data_rvalid_i && (count_q != '0);

    // Misaligned requests are completed at the handshake with an exception; they never reach the bus.
    assign mem_ready_o        = push || (mem_valid_i && misaligned);
    assign mem_resp_exc_o     = mem_valid_i && misaligned;
    assign mem_resp_exccode_o = !mem_resp_exc_o ? 6'd0 :
                                mem_req_we_i    ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_id_q[i] <= '0;
                fifo_we_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_id_q[wr_ptr_q] <= mem_req_id_i;
                fifo_we_q[wr_ptr_q] <= mem_req_we_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_result_valid_o <= 1'b0;
            mem_result_id_o    <= '0;
            mem_result_rdata_o <= 32'h0;
            mem_result_err_o   <= 1'b0;
        end else begin
            mem_result_valid_o <= pop;
            if (pop) begin
                mem_result_id_o    <= fifo_id_q[rd_ptr_q];
                mem_result_rdata_o <= fifo_we_q[rd_ptr_q] ? 32'h0 : data_rdata_i;
                mem_result_err_o   <= data_err_i;
            end
        end
    end

endmodule

// File: tb/tb_xif_mem_responder.sv
// tb/tb_xif_mem_responder.sv - directed self-checking bench for xif_mem_responder
module tb_xif_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [3:0]  mem_req_id_i;
    logic [31:0] mem_req_addr_i;
    logic        mem_req_we_i;
    logic [3:0]  mem_req_be_i;
    logic [31:0] mem_req_wdata_i;
    logic        mem_resp_exc_o;
    logic [5:0]  mem_resp_exccode_o;
    logic        mem_result_valid_o;
    logic [3:0]  mem_result_id_o;
    logic [31:0] mem_result_rdata_o;
    logic        mem_result_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    xif_mem_responder #(.X_ID_WIDTH(4), .DEPTH(2)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mem_valid_i        (mem_valid_i),
        .mem_ready_o        (mem_ready_o),
        .mem_req_id_i       (mem_req_id_i),
        .mem_req_addr_i     (mem_req_addr_i),
        .mem_req_we_i       (mem_req_we_i),
        .mem_req_be_i       (mem_req_be_i),
        .mem_req_wdata_i    (mem_req_wdata_i),
        .mem_resp_exc_o     (mem_resp_exc_o),
        .mem_resp_exccode_o (mem_resp_exccode_o),
        .mem_result_valid_o (mem_result_valid_o),
        .mem_result_id_o    (mem_result_id_o),
        .mem_result_rdata_o (mem_result_rdata_o),
        .mem_result_err_o   (mem_result_err_o),
        .data_req_o         (data_req_o),
        .data_gnt_i         (data_gnt_i),
        .data_addr_o        (data_addr_o),
        .data_we_o          (data_we_o),
        .data_be_o          (data_be_o),
        .data_wdata_o       (data_wdata_o),
        .data_rvalid_i      (data_rvalid_i),
        .data_rdata_i       (data_rdata_i),
        .data_err_i         (data_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata, input logic gnt);
        mem_valid_i     = 1'b1;
        mem_req_id_i    = id;
        mem_req_addr_i  = addr;
        mem_req_we_i    = we;
        mem_req_be_i    = be;
        mem_req_wdata_i = wdata;
        data_gnt_i      = gnt;
        #1;
    endtask

    task automatic idle_req();
        mem_valid_i = 1'b0;
        data_gnt_i  = 1'b0;
        #1;
    endtask

    task automatic resp(input logic rv, input logic [31:0] rdata, input logic err);
        data_rvalid_i = rv;
        data_rdata_i  = rdata;
        data_err_i    = err;
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [3:0] id, input logic [31:0] rdata, input logic err);
        chk({tag, "_valid"}, 32'(mem_result_valid_o), 32'd1);
        chk({tag, "_id"},    32'(mem_result_id_o),    32'(id));
        chk({tag, "_rdata"}, mem_result_rdata_o,      rdata);
        chk({tag, "_err"},   32'(mem_result_err_o),   32'(err));
    endtask

    initial begin
        rst_i = 1'b1;
        mem_valid_i = 1'b0; mem_req_id_i = '0; mem_req_addr_i = '0; mem_req_we_i = 1'b0;
        mem_req_be_i = '0; mem_req_wdata_i = '0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        #1;
        chk("rst_result_valid", 32'(mem_result_valid_o), 32'd0);
        chk("rst_result_id",    32'(mem_result_id_o),    32'd0);
        chk("rst_result_rdata", mem_result_rdata_o,      32'd0);
        chk("rst_data_req",     32'(data_req_o),         32'd0);
        chk("rst_ready",        32'(mem_ready_o),        32'd0);
        chk("rst_addr",         data_addr_o,             32'd0);
        chk("rst_exc",          32'(mem_resp_exc_o),     32'd0);

        // Single load with grant in the same cycle
        next_cycle();
        req(4'd3, 32'h100, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t1_req",   32'(data_req_o),  32'd1);
        chk("t1_ready", 32'(mem_ready_o), 32'd1);
        chk("t1_addr",  data_addr_o,      32'h100);
        chk("t1_we",    32'(data_we_o),   32'd0);
        next_cycle(); idle_req();
        chk("t1_no_early_result", 32'(mem_result_valid_o), 32'd0);
        next_cycle(); resp(1'b1, 32'hDEADBEEF, 1'b0);
        chk("t1_no_result_at_rvalid", 32'(mem_result_valid_o), 32'd0);
        next_cycle(); resp(1'b0, 32'h0, 1'b0);
        chk_result("t1", 4'd3, 32'hDEADBEEF, 1'b0);
        next_cycle();
        chk("t1_pulse_one_cycle", 32'(mem_result_valid_o), 32'd0);

        // Two outstanding fill DEPTH=2; third stalls until the first retires
        req(4'd1, 32'h200, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t2_ready_id1", 32'(mem_ready_o), 32'd1);
        next_cycle(); req(4'd2, 32'h204, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t2_ready_id2", 32'(mem_ready_o), 32'd1);
        next_cycle(); req(4'd4, 32'h208, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t2_full_req",   32'(data_req_o),  32'd0);
        chk("t2_full_ready", 32'(mem_ready_o), 32'd0);
        next_cycle();
        chk("t2_full_ready_2", 32'(mem_ready_o), 32'd0);
        resp(1'b1, 32'h11, 1'b0);
        chk("t2_pop_frees_req",   32'(data_req_o),  32'd1);
        chk("t2_pop_frees_ready", 32'(mem_ready_o), 32'd1);
        next_cycle(); idle_req(); resp(1'b0, 32'h0, 1'b0);
        chk_result("t2_r1", 4'd1, 32'h11, 1'b0);
        next_cycle(); resp(1'b1, 32'h22, 1'b0);
        chk("t2_gap", 32'(mem_result_valid_o), 32'd0);
        next_cycle(); resp(1'b1, 32'h44, 1'b0);
        chk_result("t2_r2", 4'd2, 32'h22, 1'b0);
        next_cycle(); resp(1'b0, 32'h0, 1'b0);
        chk_result("t2_r4", 4'd4, 32'h44, 1'b0);

        // Misaligned load and store complete with an exception, no bus traffic
        next_cycle();
        req(4'd7, 32'h102, 1'b0, 4'hF, 32'h0, 1'b0);
        chk("t3_ready",   32'(mem_ready_o),        32'd1);
        chk("t3_exc",     32'(mem_resp_exc_o),     32'd1);
        chk("t3_exccode", 32'(mem_resp_exccode_o), 32'd4);
        chk("t3_req",     32'(data_req_o),         32'd0);
        next_cycle(); req(4'd7, 32'h101, 1'b1, 4'hF, 32'h0, 1'b0);
        chk("t3_st_exccode", 32'(mem_resp_exccode_o), 32'd6);
        chk("t3_st_req",     32'(data_req_o),         32'd0);
        next_cycle(); idle_req();
        chk("t3_no_result", 32'(mem_result_valid_o), 32'd0);
        chk("t3_idle_exc",  32'(mem_resp_exc_o),     32'd0);

        // Store with bus error
        next_cycle();
        req(4'd5, 32'h300, 1'b1, 4'h3, 32'h12345678, 1'b1);
        chk("t4_we",    32'(data_we_o),  32'd1);
        chk("t4_be",    32'(data_be_o),  32'h3);
        chk("t4_wdata", data_wdata_o,    32'h12345678);
        next_cycle(); idle_req();
        next_cycle(); resp(1'b1, 32'hFFFF_0000, 1'b1);
        next_cycle(); resp(1'b0, 32'h0, 1'b0);
        chk_result("t4", 4'd5, 32'h0, 1'b1);

        // Grant withheld for three cycles
        next_cycle();
        req(4'd6, 32'h400, 1'b0, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_req_stable",  32'(data_req_o),  32'd1);
            chk("t5_addr_stable", data_addr_o,      32'h400);
            chk("t5_ready_low",   32'(mem_ready_o), 32'd0);
            next_cycle();
        end
        data_gnt_i = 1'b1; #1;
        chk("t5_ready_on_gnt", 32'(mem_ready_o), 32'd1);
        next_cycle(); idle_req(); resp(1'b1, 32'h55, 1'b0);
        next_cycle(); resp(1'b0, 32'h0, 1'b0);
        chk_result("t5", 4'd6, 32'h55, 1'b0);

        // Reset with two outstanding drops them
        next_cycle();
        req(4'd7, 32'h500, 1'b0, 4'hF, 32'h0, 1'b1);
        next_cycle(); req(4'd8, 32'h504, 1'b0, 4'hF, 32'h0, 1'b1);
        next_cycle(); idle_req(); rst_i = 1'b1; #1;
        next_cycle(); rst_i = 1'b0; #1;
        chk("t6_result_valid", 32'(mem_result_valid_o), 32'd0);
        resp(1'b1, 32'h77, 1'b0);
        next_cycle(); resp(1'b0, 32'h0, 1'b0);
        chk("t6_stray_no_result", 32'(mem_result_valid_o), 32'd0);
        req(4'd9, 32'h600, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t6_ready_a", 32'(mem_ready_o), 32'd1);
        next_cycle(); req(4'd10, 32'h604, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t6_ready_b", 32'(mem_ready_o), 32'd1);
        next_cycle(); req(4'd11, 32'h608, 1'b0, 4'hF, 32'h0, 1'b1);
        chk("t6_full_again", 32'(mem_ready_o), 32'd0);
        next_cycle(); idle_req();
        chk("t6_idle_req", 32'(data_req_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
